// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the two-requester ROM read-port arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_LD = 1'b1
  } port_id_t;

  function automatic int dw(input int extra_w);
    return (2 ** extra_w) * 8;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the port not granted last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  port_id_t   last_grant,
  output logic [1:0] gnt
);

  // NOTE: gnt gets a default before any branch so no latch is inferred.
  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = (last_grant == PORT_IF) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one genrom-style read port between instruction fetch (IF) and data load (LD),
// one access at a time with a fixed ROM latency.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter  int MEM_ADDR    = 4,
  parameter  int MEM_EXTRA   = 4,
  parameter  int ROM_LATENCY = 1,
  localparam int DW          = dw(MEM_EXTRA)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 if_req_valid,
  input  logic [MEM_ADDR:0]    if_req_addr,
  input  logic [MEM_EXTRA-1:0] if_req_extra,
  output logic                 if_req_ready,
  output logic                 if_rsp_valid,
  input  logic                 ld_req_valid,
  input  logic [MEM_ADDR:0]    ld_req_addr,
  input  logic [MEM_EXTRA-1:0] ld_req_extra,
  output logic                 ld_req_ready,
  output logic                 ld_rsp_valid,
  output logic [DW-1:0]        rsp_data,
  output logic                 rsp_error,
  output logic [MEM_ADDR:0]    mem_addr,
  output logic [MEM_EXTRA-1:0] mem_extra,
  input  logic [DW-1:0]        mem_data,
  input  logic                 mem_error,
  output logic                 busy
);

  localparam logic [2:0] LAT = 3'(ROM_LATENCY);

  arb_state_t state;
  port_id_t   owner;
  port_id_t   last_grant;
  logic [2:0] cnt;
  logic [1:0] gnt;
  logic [1:0] grant;
  logic       can_accept;

  rr_arb2 u_rr_arb2 (
    .req        ({ld_req_valid, if_req_valid}),
    .last_grant (last_grant),
    .gnt        (gnt)
  );

  // A new access may start while the previous response is being presented.
  assign can_accept   = !reset && (state == IDLE || state == RESP);
  assign grant        = can_accept ? gnt : 2'b00;
  assign if_req_ready = grant[0];
  assign ld_req_ready = grant[1];

  assign if_rsp_valid = !reset && state == RESP && owner == PORT_IF;
  assign ld_rsp_valid = !reset && state == RESP && owner == PORT_LD;
  assign busy         = (state == WAIT);

  // NOTE: all state is updated with non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      owner      <= PORT_IF;
      last_grant <= PORT_LD;
      mem_addr   <= '0;
      mem_extra  <= '0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
    end else begin
      unique case (state)
        IDLE, RESP: begin
          if (grant[1]) begin
            owner      <= PORT_LD;
            last_grant <= PORT_LD;
            mem_addr   <= ld_req_addr;
            mem_extra  <= ld_req_extra;
            cnt        <= LAT;
            state      <= WAIT;
          end else if (grant[0]) begin
            owner      <= PORT_IF;
            last_grant <= PORT_IF;
            mem_addr   <= if_req_addr;
            mem_extra  <= if_req_extra;
            cnt        <= LAT;
            state      <= WAIT;
          end else begin
            state <= IDLE;
          end
        end
        WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rsp_data  <= mem_data;
            rsp_error <= mem_error;
            state     <= RESP;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the core's single ROM/memory read port (`mem_addr`/`mem_extra`/`mem_data`/`mem_error`, genrom-style) between two requesters:
  - instruction fetch (IF);
  - data load (LD, e.g. immediate/const operand or linear-memory reads).
- Sits between the core pipeline and genrom.
- Accepts one access at a time, round-robin arbitrates when both requesters are pending, waits a fixed ROM latency, then returns data and error to the winner.

Parameters:
- MEM_ADDR, 4, address MSB index; address ports are MEM_ADDR+1 bits wide.
- MEM_EXTRA, 4, extra-size field width; data width DW = 2**MEM_EXTRA*8 (128 by default).
- ROM_LATENCY, 1, edges from address-stable to `mem_data` valid; range 1..7.

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- if_req_valid  in  1  fetch request pending
- if_req_addr  in  MEM_ADDR+1  fetch address
- if_req_extra  in  MEM_EXTRA  fetch size field
- if_req_ready  out  1  fetch request accepted this cycle
- if_rsp_valid  out  1  one-cycle pulse; `rsp_data`/`rsp_error` belong to IF
- ld_req_valid  in  1  load request pending
- ld_req_addr  in  MEM_ADDR+1  load address
- ld_req_extra  in  MEM_EXTRA  load size field
- ld_req_ready  out  1  load request accepted this cycle
- ld_rsp_valid  out  1  one-cycle pulse; response belongs to LD
- rsp_data  out  DW  shared response data
- rsp_error  out  1  shared response error
- mem_addr  out  MEM_ADDR+1  to ROM
- mem_extra  out  MEM_EXTRA  to ROM
- mem_data  in  DW  from ROM
- mem_error  in  1  from ROM
- busy  out  1  access in flight (state WAIT)

Behaviour:
- Reset, synchronous, active-high; values next edge:
  - state=IDLE, cnt=0, last_grant=LD (so IF wins the first tie);
  - `mem_addr`=0, `mem_extra`=0, `rsp_data`=0, `rsp_error`=0;
  - all `*_rsp_valid`=0, `busy`=0;
  - `*_req_ready`=0 while `reset` is high.
- States:
  - IDLE: no access.
  - WAIT: access in flight; `cnt` counts down.
  - RESP: response pulse cycle.
- Accept:
  - Permitted in IDLE or RESP.
  - Winner: the single valid requester; if both are valid, the one not equal to `last_grant`.
  - `req_ready` is combinational from valid and state, asserted for the winner only.
  - Requester holds addr/extra stable while valid and not ready. The arbiter never drops a pending request.
- On the accept edge:
  - latch winner addr/extra into `mem_addr`/`mem_extra`;
  - store owner; `last_grant`=owner;
  - `cnt`=ROM_LATENCY; go to WAIT.
- `mem_addr`/`mem_extra` hold their value until the next accept.
- WAIT: `cnt` decrements each edge. When `cnt`==1:
  - capture `mem_data`/`mem_error` into `rsp_data`/`rsp_error`;
  - go to RESP.
- RESP:
  - owner's `rsp_valid`=1 for exactly one cycle.
  - A new accept in the same cycle goes to WAIT; otherwise go to IDLE.
  - `rsp_data`/`rsp_error` hold until the next capture.
- Latency: request accepted in cycle 0 → `rsp_valid` in cycle ROM_LATENCY+1.
- Throughput: one access per ROM_LATENCY+1 cycles under continuous demand.
- Boundary conditions:
  - Both valid continuously: grants alternate IF, LD, IF, … No starvation; worst-case wait is one access.
  - `mem_error`=1 at capture: propagated as `rsp_error`=1 with `rsp_data` as sampled. The arbiter never retries.
  - Requests arriving during WAIT: `ready`=0, requests queue implicitly via held valid.
  - Reset mid-WAIT or mid-RESP: access abandoned, no `rsp_valid` emitted, IDLE next cycle.
  - Never both `if_rsp_valid` and `ld_rsp_valid` high; never both `ready`s high.

Decomposition:
- Package `mem_arb_pkg`:
  - `arb_state_t` enum {IDLE, WAIT, RESP};
  - `port_id_t` enum {PORT_IF, PORT_LD};
  - function `dw(extra_w)` returning 2**extra_w*8.
- One sub-module `rr_arb2`: combinational two-way round-robin pick. Inputs: req[1:0], last_grant. Outputs: gnt[1:0] one-hot.

Test Plan:
- Bench uses a behavioural ROM with byte[a]=a and `mem_error`=1 when addr>0x1C.
- Single IF req addr=0x03, extra=0, ROM_LATENCY=1 → `if_req_ready` cycle 0; `if_rsp_valid` cycle 2; `rsp_data[7:0]`=0x03; `rsp_error`=0; `ld_rsp_valid` stays 0.
- IF and LD both valid from reset release (IF 0x01, LD 0x05) → IF granted first, LD accepted in IF's RESP cycle. Responses 0x01 then 0x05, two cycles apart.
- Both held valid for 8 accesses → grant order IF, LD, IF, LD, …; no more than one grant per 2 cycles.
- LD addr=0x1E → `ld_rsp_valid`=1 with `rsp_error`=1.
- ROM_LATENCY=3, IF req → `rsp_valid` in cycle 4; `busy` high cycles 1–3.
- Reset asserted in WAIT → no `rsp_valid`; next cycle all outputs at reset values; fresh IF req completes normally.
